pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use clock clk and reset rst; reset is synchronous and active-high.
REQ-002 Port clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port rst  input  1  synchronous active-high reset.
REQ-004 Port stallreq_id  input  1  decode-stage stall request (operand hazard), combinational.
REQ-005 Port stallreq_ex  input  1  execute-stage single-cycle stall request, combinational.
REQ-006 Port mc_req  input  1  EX presents a multi-cycle operation this cycle.
REQ-007 Port mc_kind  input  2  00 none, 01 madd/msub (len 2), 10 div (len 34), 11 reserved.
REQ-008 Port mc_cancel  input  1  abort in-flight multi-cycle op (flush/annul).
REQ-009 Port stall  output  6  per-stage hold vector: bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb; 1 = Stop.
REQ-010 Port mc_busy  output  1  high in accept cycle and every RUN cycle.
REQ-011 Port mc_done  output  1  single-cycle pulse in DONE state.
REQ-012 Port mc_cnt  output  6  current step index of multi-cycle op.
REQ-013 Port stall_cycles  output  32  count of cycles with stall[0]=1.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; encoding is free.
REQ-015 Accept condition: state IDLE, mc_req=1, mc_kind in {01,10}, mc_cancel=0; mc_kind 00/11 with mc_req SHALL be ignored.
REQ-016 Accept cycle is step 0; mc_cnt SHALL read 0 in IDLE.
REQ-017 On accept with len 2, next state SHALL be DONE with mc_cnt=1.
REQ-018 On accept with len 34, next state SHALL be RUN with mc_cnt=1; kind latched internally.
REQ-019 In RUN, mc_cnt SHALL increment by 1 per cycle; when mc_cnt=len-2, next state DONE with mc_cnt=len-1 (33).
REQ-020 DONE SHALL last exactly one cycle, assert mc_done, then return to IDLE with mc_cnt=0.
REQ-021 Total op latency SHALL be len cycles, of which len-1 (accept + RUN) are stalled.
REQ-022 mc_req while not IDLE SHALL be ignored; no queuing.
REQ-023 mc_cancel in RUN SHALL force IDLE next cycle, mc_cnt=0, no mc_done pulse; mc_busy stays high in the cancel cycle.
REQ-024 mc_cancel in DONE SHALL be ignored; mc_done still pulses.
REQ-025 stall SHALL be combinational: 6'b001111 if stallreq_ex or mc_busy; else 6'b000111 if stallreq_id; else 6'b000000.
REQ-026 EX-level request SHALL take priority over ID-level request when both present.
REQ-027 stall[5:4] SHALL always be 0; mem/wb never held.
REQ-028 stall_cycles SHALL increment on each clock edge where stall[0]=1, saturating at 32'hFFFFFFFF.

Reset
REQ-029 While rst=1, stall, mc_busy, mc_done SHALL be 0 regardless of inputs.
REQ-030 On rst edge: state IDLE, mc_cnt 0, stall_cycles 0; reset mid-operation SHALL abandon the op with no mc_done.
REQ-031 First cycle after rst deassert SHALL accept a valid mc_req.

Verification
REQ-032 madd: mc_req=1, kind=01 at cycle 0 -> stall=001111 cycle 0, mc_done=1 and stall=0 cycle 1, stall_cycles=1.
REQ-033 div: mc_req=1, kind=10 at cycle 0 -> stall=001111 cycles 0..32, mc_cnt=33 and mc_done=1 at cycle 33, stall_cycles=33.
REQ-034 Priority: stallreq_id=1 and stallreq_ex=1 same cycle, IDLE -> stall=001111; stallreq_id alone -> 000111.
REQ-035 Cancel: div accepted, mc_cancel=1 at mc_cnt=10 -> IDLE next cycle, mc_cnt=0, mc_done never asserted.
REQ-036 Reset mid-op: rst=1 at mc_cnt=20 -> stall=0 that cycle, IDLE after, stall_cycles=0; mc_req in first post-reset cycle accepted.
REQ-037 Ignore: mc_kind=11 with mc_req=1 -> stall=0, mc_busy=0; mc_req during RUN -> mc_cnt sequence unchanged.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stall requests and multi-cycle op handshake
// from the datapath, per-stage hold vector and op status back to it.
interface pipe_ctrl_if;
    logic        stallreq_id;   // decode-stage operand hazard
    logic        stallreq_ex;   // execute-stage single-cycle hold
    logic        mc_req;        // EX presents a multi-cycle op
    logic [1:0]  mc_kind;       // 01 madd/msub, 10 div
    logic        mc_cancel;     // abort an in-flight op
    logic [5:0]  stall;         // per-stage hold: pc, if, id, ex, mem, wb
    logic        mc_busy;       // op accepted this cycle or running
    logic        mc_done;       // op completes this cycle
    logic [5:0]  mc_cnt;        // current step of the op
    logic [31:0] stall_cycles;  // cycles with the pc held

    // Datapath side: raises requests, observes holds
    modport master (
        output stallreq_id, stallreq_ex, mc_req, mc_kind, mc_cancel,
        input  stall, mc_busy, mc_done, mc_cnt, stall_cycles
    );

    // Controller side
    modport slave (
        input  stallreq_id, stallreq_ex, mc_req, mc_kind, mc_cancel,
        output stall, mc_busy, mc_done, mc_cnt, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: merges ID/EX stall requests with a
// multi-cycle operation sequencer (madd/msub 2 steps, div 34 steps)
// into a 6-bit per-stage hold vector, and counts stalled cycles.
module pipe_ctrl (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    localparam logic [1:0] KIND_MADD = 2'b01;
    localparam logic [1:0] KIND_DIV  = 2'b10;

    // Step index at which RUN hands over to DONE is len-2.
    localparam logic [5:0] DIV_LAST_RUN = 6'd32;   // len 34
    localparam logic [5:0] MADD_LAST    = 6'd0;    // len 2, never runs

    // Hold patterns: EX-level holds pc..ex, ID-level holds pc..id.
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [5:0]  r_last;          // latched last RUN step for the op kind
    logic [31:0] r_stall_cycles;

    logic        w_kind_valid;
    logic        w_accept;
    logic        w_busy;
    logic        w_done;
    logic [5:0]  w_stall;

    // Only madd and div are real multi-cycle ops; 00/11 are dropped.
    assign w_kind_valid = (bus.mc_kind == KIND_MADD) || (bus.mc_kind == KIND_DIV);

    // A request is taken only from IDLE; anything else is ignored, no queue.
    assign w_accept = (r_state == S_IDLE) && bus.mc_req && w_kind_valid && !bus.mc_cancel;

    // Busy covers the accept cycle (combinational) and every RUN cycle,
    // including a RUN cycle that is being cancelled. Forced low in reset.
    assign w_busy = !rst && (w_accept || (r_state == S_RUN));
    assign w_done = !rst && (r_state == S_DONE);

    // Hold vector: EX-level wins over ID-level; mem/wb are never held.
    always_comb begin
        w_stall = STALL_NONE;
        if (rst) begin
            w_stall = STALL_NONE;
        end else if (bus.stallreq_ex || w_busy) begin
            w_stall = STALL_EX;
        end else if (bus.stallreq_id) begin
            w_stall = STALL_ID;
        end
    end

    // Multi-cycle sequencer: IDLE -> (RUN ->) DONE -> IDLE, step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_last  <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= 6'd1;
                        if (bus.mc_kind == KIND_DIV) begin
                            r_state <= S_RUN;
                            r_last  <= DIV_LAST_RUN;
                        end else begin
                            // Two-step op: step 1 is already the final step
                            r_state <= S_DONE;
                            r_last  <= MADD_LAST;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.mc_cancel) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 6'd0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == r_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Cancel is too late here: the op has completed
                    r_state <= S_IDLE;
                    r_cnt   <= 6'd0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 6'd0;
                end
            endcase
        end
    end

    // Count cycles in which the pc is held, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
        end else if (w_stall[0] && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.mc_busy      = w_busy;
    assign bus.mc_done      = w_done;
    assign bus.mc_cnt       = r_cnt;
    assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: madd, div, priority, cancel,
// reset mid-op and ignored requests, with hand-computed expectations.
module tb_pipe_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance to 1 ns after the next rising edge, then let inputs settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stallreq_id = 1'b0;
        bus.stallreq_ex = 1'b0;
        bus.mc_req      = 1'b0;
        bus.mc_kind     = 2'b00;
        bus.mc_cancel   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle_inputs();
        tick();

        // Reset dominates: active inputs must not show on outputs
        bus.mc_req = 1'b1; bus.mc_kind = 2'b10; bus.stallreq_ex = 1'b1; bus.stallreq_id = 1'b1;
        #2;
        check("rst_stall", {26'd0, bus.stall}, 32'h0);
        check("rst_busy",  {31'd0, bus.mc_busy}, 32'h0);
        check("rst_done",  {31'd0, bus.mc_done}, 32'h0);
        tick();
        #2;
        check("rst_cnt", {26'd0, bus.mc_cnt}, 32'd0);
        check("rst_sc",  bus.stall_cycles, 32'd0);
        idle_inputs();
        rst = 1'b0;

        // madd: accept in first post-reset cycle
        bus.mc_req = 1'b1; bus.mc_kind = 2'b01;
        #2;
        check("madd_c0_stall", {26'd0, bus.stall}, 32'h0f);
        check("madd_c0_busy",  {31'd0, bus.mc_busy}, 32'd1);
        check("madd_c0_cnt",   {26'd0, bus.mc_cnt}, 32'd0);
        tick();
        idle_inputs();
        #2;
        check("madd_c1_done",  {31'd0, bus.mc_done}, 32'd1);
        check("madd_c1_stall", {26'd0, bus.stall}, 32'h0);
        check("madd_c1_cnt",   {26'd0, bus.mc_cnt}, 32'd1);
        check("madd_c1_sc",    bus.stall_cycles, 32'd1);
        tick();
        #2;
        check("madd_c2_done", {31'd0, bus.mc_done}, 32'd0);
        check("madd_c2_cnt",  {26'd0, bus.mc_cnt}, 32'd0);

        // div: 34 cycles, 33 stalled; stray madd request mid-run is ignored
        bus.mc_req = 1'b1; bus.mc_kind = 2'b10;
        #2;
        check("div_c0_stall", {26'd0, bus.stall}, 32'h0f);
        tick();
        idle_inputs();
        for (int i = 1; i <= 32; i++) begin
            if (i == 5) begin
                bus.mc_req = 1'b1; bus.mc_kind = 2'b01;
            end else begin
                bus.mc_req = 1'b0; bus.mc_kind = 2'b00;
            end
            #2;
            check($sformatf("div_c%0d_cnt", i),   {26'd0, bus.mc_cnt}, i);
            check($sformatf("div_c%0d_stall", i), {26'd0, bus.stall}, 32'h0f);
            check($sformatf("div_c%0d_done", i),  {31'd0, bus.mc_done}, 32'd0);
            tick();
        end
        idle_inputs();
        #2;
        check("div_c33_cnt",   {26'd0, bus.mc_cnt}, 32'd33);
        check("div_c33_done",  {31'd0, bus.mc_done}, 32'd1);
        check("div_c33_stall", {26'd0, bus.stall}, 32'h0);
        check("div_c33_sc",    bus.stall_cycles, 32'd34);
        tick();
        #2;
        check("div_c34_cnt",  {26'd0, bus.mc_cnt}, 32'd0);
        check("div_c34_done", {31'd0, bus.mc_done}, 32'd0);

        // Priority, combinational only (no clock edge while requests held)
        bus.stallreq_id = 1'b1; bus.stallreq_ex = 1'b1;
        #1;
        check("prio_both", {26'd0, bus.stall}, 32'h0f);
        bus.stallreq_ex = 1'b0;
        #1;
        check("prio_id",   {26'd0, bus.stall}, 32'h07);
        bus.stallreq_id = 1'b0; bus.stallreq_ex = 1'b1;
        #1;
        check("prio_ex",   {26'd0, bus.stall}, 32'h0f);
        bus.stallreq_ex = 1'b0;
        #1;
        check("prio_none", {26'd0, bus.stall}, 32'h0);
        tick();

        // Cancel at accept: request is not taken
        bus.mc_req = 1'b1; bus.mc_kind = 2'b10; bus.mc_cancel = 1'b1;
        #2;
        check("canacc_busy", {31'd0, bus.mc_busy}, 32'd0);
        tick();
        idle_inputs();
        #2;
        check("canacc_cnt", {26'd0, bus.mc_cnt}, 32'd0);

        // Cancel during RUN at mc_cnt=10
        bus.mc_req = 1'b1; bus.mc_kind = 2'b10;
        tick();
        idle_inputs();
        for (int i = 1; i < 10; i++) tick();
        bus.mc_cancel = 1'b1;
        #2;
        check("cancel_cnt10",  {26'd0, bus.mc_cnt}, 32'd10);
        check("cancel_busy",   {31'd0, bus.mc_busy}, 32'd1);
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            #2;
            check($sformatf("cancel_after%0d_cnt", i),  {26'd0, bus.mc_cnt}, 32'd0);
            check($sformatf("cancel_after%0d_done", i), {31'd0, bus.mc_done}, 32'd0);
            check($sformatf("cancel_after%0d_busy", i), {31'd0, bus.mc_busy}, 32'd0);
            tick();
        end
        // 34 + 11 stalled cycles (accept + steps 1..10)
        check("cancel_sc", bus.stall_cycles, 32'd45);

        // Cancel in DONE is ignored
        bus.mc_req = 1'b1; bus.mc_kind = 2'b01;
        tick();
        idle_inputs();
        bus.mc_cancel = 1'b1;
        #2;
        check("cdone_done", {31'd0, bus.mc_done}, 32'd1);
        tick();
        idle_inputs();
        #2;
        check("cdone_after_cnt", {26'd0, bus.mc_cnt}, 32'd0);
        check("cdone_sc", bus.stall_cycles, 32'd46);

        // Reset at mc_cnt=20 abandons the op
        bus.mc_req = 1'b1; bus.mc_kind = 2'b10;
        tick();
        idle_inputs();
        for (int i = 1; i < 20; i++) tick();
        #2;
        check("rstmid_cnt20", {26'd0, bus.mc_cnt}, 32'd20);
        rst = 1'b1;
        #1;
        check("rstmid_stall", {26'd0, bus.stall}, 32'h0);
        check("rstmid_busy",  {31'd0, bus.mc_busy}, 32'd0);
        tick();
        rst = 1'b0;
        #2;
        check("rstmid_cnt", {26'd0, bus.mc_cnt}, 32'd0);
        check("rstmid_sc",  bus.stall_cycles, 32'd0);
        bus.mc_req = 1'b1; bus.mc_kind = 2'b01;
        #1;
        check("rstmid_acc_busy",  {31'd0, bus.mc_busy}, 32'd1);
        check("rstmid_acc_stall", {26'd0, bus.stall}, 32'h0f);
        tick();
        idle_inputs();
        #2;
        check("rstmid_done", {31'd0, bus.mc_done}, 32'd1);
        check("rstmid_sc1",  bus.stall_cycles, 32'd1);
        tick();

        // Reserved and none kinds are ignored
        bus.mc_req = 1'b1; bus.mc_kind = 2'b11;
        #2;
        check("k11_stall", {26'd0, bus.stall}, 32'h0);
        check("k11_busy",  {31'd0, bus.mc_busy}, 32'd0);
        tick();
        bus.mc_kind = 2'b00;
        #2;
        check("k11_cnt",  {26'd0, bus.mc_cnt}, 32'd0);
        check("k11_done", {31'd0, bus.mc_done}, 32'd0);
        check("k00_busy", {31'd0, bus.mc_busy}, 32'd0);
        tick();
        idle_inputs();
        #2;
        check("k00_cnt", {26'd0, bus.mc_cnt}, 32'd0);
        check("k_sc",    bus.stall_cycles, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
